// File: rtl/update_read_bit_index_if.sv
// PS/2 receiver bus: the sampled data line plus the decoded frame outputs.
// The master drives ps2data; the slave (the receiver) drives everything else.
interface update_read_bit_index_if;
  logic       ps2data;
  logic [3:0] bitIndex;
  logic [7:0] data;
  logic       frame_valid;
  logic       frame_err;
  logic [6:0] ssd;

  modport master (
    output ps2data,
    input  bitIndex, data, frame_valid, frame_err, ssd
  );

  modport slave (
    input  ps2data,
    output bitIndex, data, frame_valid, frame_err, ssd
  );
endinterface

// File: rtl/update_read_bit_index.sv
// PS/2 frame receiver: tracks the bit position in the 11-bit frame, assembles the scancode,
// checks framing and decodes the last good code to a 7-segment glyph. Macro: UPDATE_READ_BIT_INDEX_PARITY_EN.
module update_read_bit_index #(
  parameter bit SSD_ACTIVE_LOW = 1'b1
) (
  input logic CLK,
  input logic RST,
  update_read_bit_index_if.slave bus
);

  localparam logic [3:0] IDX_START  = 4'd0;
  localparam logic [3:0] IDX_PARITY = 4'd9;
  localparam logic [3:0] IDX_STOP   = 4'd10;

  logic [3:0] r_bit_index;
  logic [7:0] r_shift;
  logic [7:0] r_data;
  logic       r_frame_valid;
  logic       r_frame_err;
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
  logic       r_parity;
`endif

  logic       w_frame_good;
  logic [6:0] w_glyph_al;

  // Frame judgement uses the stop bit arriving on this very edge.
  always_comb begin
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
    w_frame_good = bus.ps2data & (^{r_shift, r_parity});
`else
    w_frame_good = bus.ps2data;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_bit_index   <= IDX_START;
      r_shift       <= 8'h00;
      r_data        <= 8'h00;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
      r_parity      <= 1'b0;
`endif
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_bit_index)
        IDX_START: begin
          // A high line at the start position is idle; stay put to resynchronise.
          if (!bus.ps2data) r_bit_index <= 4'd1;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          r_shift[3'(r_bit_index - 4'd1)] <= bus.ps2data;
          r_bit_index                     <= r_bit_index + 4'd1;
        end
        IDX_PARITY: begin
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
          r_parity <= bus.ps2data;
`endif
          r_bit_index <= IDX_STOP;
        end
        IDX_STOP: begin
          r_bit_index <= IDX_START;
          if (w_frame_good) begin
            r_data        <= r_shift;
            r_frame_valid <= 1'b1;
          end else begin
            r_frame_err   <= 1'b1;
          end
        end
        default: r_bit_index <= IDX_START;
      endcase
    end
  end

  // Set-2 scancode to active-low glyph, bit order {g,f,e,d,c,b,a}.
  // NOTE: default assignment first so the decode can never infer a latch.
  always_comb begin
    w_glyph_al = 7'h7F;
    case (r_data)
      8'h45: w_glyph_al = 7'h40;
      8'h16: w_glyph_al = 7'h79;
      8'h1E: w_glyph_al = 7'h24;
      8'h26: w_glyph_al = 7'h30;
      8'h25: w_glyph_al = 7'h19;
      8'h2E: w_glyph_al = 7'h12;
      8'h36: w_glyph_al = 7'h02;
      8'h3D: w_glyph_al = 7'h78;
      8'h3E: w_glyph_al = 7'h00;
      8'h46: w_glyph_al = 7'h10;
      8'h1C: w_glyph_al = 7'h08;
      8'h32: w_glyph_al = 7'h03;
      8'h21: w_glyph_al = 7'h46;
      8'h23: w_glyph_al = 7'h21;
      8'h24: w_glyph_al = 7'h06;
      8'h2B: w_glyph_al = 7'h0E;
      default: w_glyph_al = 7'h7F;
    endcase
  end

  assign bus.bitIndex    = r_bit_index;
  assign bus.data        = r_data;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;
  assign bus.ssd         = SSD_ACTIVE_LOW ? w_glyph_al : ~w_glyph_al;

endmodule

// File: tb/tb_update_read_bit_index.sv
// Bench for update_read_bit_index: directed frames plus randomized frame streams checked
// against a queue-based frame model. Honours UPDATE_READ_BIT_INDEX_PARITY_EN.
module tb_update_read_bit_index;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  update_read_bit_index_if bus ();

  update_read_bit_index #(.SSD_ACTIVE_LOW(1'b1)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bits of the frame in progress, last good byte, pulses of the last edge.
  logic       m_q[$];
  logic [7:0] m_data = 8'h00;
  logic       m_fv   = 1'b0;
  logic       m_fe   = 1'b0;

  function automatic logic [6:0] exp_glyph(input logic [7:0] c);
    case (c)
      8'h45: return 7'h40;  8'h16: return 7'h79;  8'h1E: return 7'h24;  8'h26: return 7'h30;
      8'h25: return 7'h19;  8'h2E: return 7'h12;  8'h36: return 7'h02;  8'h3D: return 7'h78;
      8'h3E: return 7'h00;  8'h46: return 7'h10;  8'h1C: return 7'h08;  8'h32: return 7'h03;
      8'h21: return 7'h46;  8'h23: return 7'h21;  8'h24: return 7'h06;  8'h2B: return 7'h0E;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Drive one PS/2 clock edge and advance the model to match the post-edge state.
  task automatic tick(input logic b, input logic r);
    logic [7:0] byte_v;
    logic       good;
    @(negedge CLK);
    RST         = r;
    bus.ps2data = b;
    @(posedge CLK);
    #1;
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_q.delete();
      m_data = 8'h00;
    end else if (!(m_q.size() == 0 && b)) begin
      m_q.push_back(b);
      if (m_q.size() == 11) begin
        for (int i = 0; i < 8; i++) byte_v[i] = m_q[i+1];
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
        good = m_q[10] && ((^byte_v) ^ m_q[9]);
`else
        good = m_q[10];
`endif
        if (good) begin
          m_data = byte_v;
          m_fv   = 1'b1;
        end else begin
          m_fe   = 1'b1;
        end
        m_q.delete();
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < 11; i++) tick(f[i], 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    n_cmp++; if (bus.bitIndex !== 4'd0) begin n_err++; $display("FAIL reset_idx got %0d want 0", bus.bitIndex); end
    n_cmp++; if (bus.data !== 8'h00) begin n_err++; $display("FAIL reset_data got %h want 00", bus.data); end
    n_cmp++; if (bus.ssd !== 7'h7F) begin n_err++; $display("FAIL reset_ssd got %h want 7f", bus.ssd); end
    n_cmp++; if (bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses got fv=%b fe=%b want 0 0", bus.frame_valid, bus.frame_err);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b1, 1'b0);
      if (bus.bitIndex !== 4'd0 || bus.frame_valid !== 1'b0 || bus.frame_err !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL idle_hold got %0d bad edges want 0", bad); end
  endtask

  task automatic test_frame_16();
    logic [10:0] f;
    f = {1'b1, 1'b0, 8'h16, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tick(f[i], 1'b0);
      n_cmp++; if (bus.bitIndex !== 4'((i + 1) % 11)) begin
        n_err++; $display("FAIL f16_idx edge %0d got %0d want %0d", i, bus.bitIndex, (i + 1) % 11);
      end
    end
    n_cmp++; if (bus.data !== 8'h16) begin n_err++; $display("FAIL f16_data got %h want 16", bus.data); end
    n_cmp++; if (bus.ssd !== 7'h79) begin n_err++; $display("FAIL f16_ssd got %h want 79", bus.ssd); end
    n_cmp++; if (bus.frame_valid !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_err++; $display("FAIL f16_pulse got fv=%b fe=%b want 1 0", bus.frame_valid, bus.frame_err);
    end
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.frame_valid !== 1'b0) begin n_err++; $display("FAIL f16_pulse_clear got %b want 0", bus.frame_valid); end
  endtask

  task automatic test_stop_err();
    send_frame(8'h45, odd_parity(8'h45), 1'b0);
    n_cmp++; if (bus.frame_err !== 1'b1 || bus.frame_valid !== 1'b0) begin
      n_err++; $display("FAIL stop_err got fv=%b fe=%b want 0 1", bus.frame_valid, bus.frame_err);
    end
    n_cmp++; if (bus.data !== 8'h16 || bus.ssd !== 7'h79) begin
      n_err++; $display("FAIL stop_keep got data=%h ssd=%h want 16 79", bus.data, bus.ssd);
    end
    tick(1'b1, 1'b0);
    n_cmp++; if (bus.frame_err !== 1'b0) begin n_err++; $display("FAIL stop_err_clear got %b want 0", bus.frame_err); end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef UPDATE_READ_BIT_INDEX_PARITY_EN
    n_cmp++; if (bus.frame_err !== 1'b1 || bus.data !== 8'h16) begin
      n_err++; $display("FAIL parity_bad got fe=%b data=%h want 1 16", bus.frame_err, bus.data);
    end
`else
    n_cmp++; if (bus.frame_valid !== 1'b1 || bus.data !== 8'h1C || bus.ssd !== 7'h08) begin
      n_err++; $display("FAIL parity_ignored got fv=%b data=%h ssd=%h want 1 1c 08",
                        bus.frame_valid, bus.data, bus.ssd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) tick((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
    n_cmp++; if (bus.bitIndex !== 4'd5) begin n_err++; $display("FAIL mid_pre_idx got %0d want 5", bus.bitIndex); end
    tick(1'b0, 1'b1);
    n_cmp++; if (bus.bitIndex !== 4'd0) begin n_err++; $display("FAIL mid_rst_idx got %0d want 0", bus.bitIndex); end
    send_frame(8'h2B, odd_parity(8'h2B), 1'b1);
    n_cmp++; if (bus.data !== 8'h2B || bus.ssd !== 7'h0E || bus.frame_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_frame got data=%h ssd=%h fv=%b want 2b 0e 1", bus.data, bus.ssd, bus.frame_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0]  codes[18] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                               8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'hF0, 8'hE0};
    logic [7:0]  b;
    logic [10:0] f;
    logic        par;
    int          gap;
    for (int n = 0; n < 60; n++) begin
      b   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 17)];
      par = odd_parity(b) ^ ($urandom_range(0, 4) == 0);
      f   = {($urandom_range(0, 6) != 0), par, b, 1'b0};
      gap = $urandom_range(0, 3);
      for (int i = 0; i < 11 + gap; i++) begin
        tick((i < 11) ? f[i] : 1'b1, ($urandom_range(0, 199) == 0));
        n_cmp++;
        if (bus.bitIndex !== 4'(m_q.size()) || bus.data !== m_data || bus.ssd !== exp_glyph(m_data) ||
            bus.frame_valid !== m_fv || bus.frame_err !== m_fe) begin
          n_err++;
          $display("FAIL rand frame %0d edge %0d got idx=%0d data=%h ssd=%h fv=%b fe=%b want idx=%0d data=%h ssd=%h fv=%b fe=%b",
                   n, i, bus.bitIndex, bus.data, bus.ssd, bus.frame_valid, bus.frame_err,
                   m_q.size(), m_data, exp_glyph(m_data), m_fv, m_fe);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      send_frame(b, odd_parity(b), 1'b1);
      n_cmp++;
      if (bus.data !== b || bus.frame_valid !== 1'b1 || bus.frame_err !== 1'b0 || bus.bitIndex !== 4'd0) begin
        n_err++;
        $display("FAIL b2b frame %0d got data=%h fv=%b fe=%b idx=%0d want %h 1 0 0",
                 n, bus.data, bus.frame_valid, bus.frame_err, bus.bitIndex, b);
      end
    end
    send_frame(8'hF0, odd_parity(8'hF0), 1'b1);
    n_cmp++; if (bus.data !== 8'hF0 || bus.ssd !== 7'h7F) begin
      n_err++; $display("FAIL break_prefix got data=%h ssd=%h want f0 7f", bus.data, bus.ssd);
    end
  endtask

  initial begin
    bus.ps2data = 1'b1;
    RST         = 1'b1;
    test_reset();
    test_idle();
    test_frame_16();
    test_stop_err();
    test_parity();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
